// File: rtl/mmio_fifo_pkg.sv
// Shared constants, types and helpers for the MMIO command/data queue.
package mmio_fifo_pkg;

  localparam int unsigned FIFO_DATA_W = 64;
  localparam int unsigned FIFO_DEPTH  = 8;

  typedef logic [FIFO_DATA_W-1:0] t_fifo_word;

  localparam logic [15:0] FIFO_DATA   = 16'h0020;
  localparam logic [15:0] FIFO_STATUS = 16'h0022;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_BOTH
  } t_fifo_op;

  // Status word for the FIFO_STATUS CSR: {44'b0, underflow, overflow, empty, full, count[15:0]}
  function automatic t_fifo_word pack_status(input logic [15:0] count,
                                             input logic        full,
                                             input logic        empty,
                                             input logic        overflow,
                                             input logic        underflow);
    return {44'b0, underflow, overflow, empty, full, count};
  endfunction

endpackage

// File: rtl/mmio_fifo_ram.sv
// FIFO storage: one write port, one registered read port, no reset.
module mmio_fifo_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the pre-write value when both ports hit the same slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mmio_pop_fifo.sv
// Host-visible queue: MMIO writes push, MMIO reads pop; status exported for CSR reads.
module mmio_pop_fifo
  import mmio_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;
  logic              ovf_evt;
  logic              unf_evt;
  logic              rd_seen;
  logic [DATA_W-1:0] ram_q;
  t_fifo_op          op;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    push_ok = wr_en && (!full || rd_en);
    pop_ok  = rd_en && !empty;
    ovf_evt = wr_en && full && !rd_en;
    unf_evt = rd_en && empty;
    op      = OP_NONE;
    case ({push_ok, pop_ok})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      rd_seen   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case (op)
        OP_PUSH: count <= count + CW'(1);
        OP_POP:  count <= count - CW'(1);
        default: count <= count;
      endcase
      rd_valid  <= pop_ok;
      rd_seen   <= rd_seen | pop_ok;
      overflow  <= ovf_evt | (overflow  & ~clr_err);
      underflow <= unf_evt | (underflow & ~clr_err);
    end
  end

  mmio_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // RAM read register has no reset; present zero until the first pop lands.
  assign rd_data = rd_seen ? ram_q : '0;

endmodule
